// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the firmware-facing request/ack path and the reset status outputs
// of the reset sequencer.
//   sys_rst_req  firmware system reset request (sampled on rising clk)
//   sys_rst_n    system reset to all cores, active-low, registered
//   sys_rst_ack  one-cycle pulse when a request is accepted
//   rst_cause    cause of last reset: 2'b01 reset_n, 2'b10 software
//   sw_rst_cnt   accepted software requests since reset_n, saturating
// Modports: master = firmware/system side, slave = the sequencer.
interface reset_sequencer_if;
    logic       sys_rst_req;
    logic       sys_rst_n;
    logic       sys_rst_ack;
    logic [1:0] rst_cause;
    logic [7:0] sw_rst_cnt;

    modport master (
        output sys_rst_req,
        input  sys_rst_n,
        input  sys_rst_ack,
        input  rst_cause,
        input  sw_rst_cnt
    );

    modport slave (
        input  sys_rst_req,
        output sys_rst_n,
        output sys_rst_ack,
        output rst_cause,
        output sw_rst_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Turns the raw asynchronous active-low reset into the stretched system reset
// for all cores. Assertion is asynchronous; release goes through a 2-flop
// synchronizer and is then held low for HOLD_CYCLES clocks. A firmware
// request in RUN replays a stretched reset, pulses an ack, records the cause
// and bumps a saturating counter.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   rs       reset_sequencer_if.slave (request in, reset/status out)
// Parameter: HOLD_CYCLES (1..255) low-hold length in clk cycles.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    reset_sequencer_if.slave  rs
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_SWRST = 2'b11
    } state_e;

    localparam logic [7:0] CTR_LAST = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [7:0] ctr_q, ctr_d;
    logic       sys_rst_n_q, sys_rst_n_d;
    logic       ack_q, ack_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] cnt_q, cnt_d;

    // Synchronizer shifts in a constant 1; stage 1 is sync_done.
    assign sync_d = {sync_q[0], 1'b1};

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        sys_rst_n_d = sys_rst_n_q;
        ack_d       = 1'b0;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_SYNC: begin
                sys_rst_n_d = 1'b0;
                ctr_d       = 8'd0;
                // Leave SYNC on the same edge that sync_done goes high, so
                // HOLD starts at the second edge after release.
                if (sync_d[1]) state_d = ST_HOLD;
            end
            ST_HOLD, ST_SWRST: begin
                sys_rst_n_d = 1'b0;
                if (ctr_q == CTR_LAST) begin
                    state_d     = ST_RUN;
                    sys_rst_n_d = 1'b1;
                    ctr_d       = 8'd0;
                end else begin
                    ctr_d = ctr_q + 8'd1;
                end
            end
            ST_RUN: begin
                sys_rst_n_d = 1'b1;
                ctr_d       = 8'd0;
                if (rs.sys_rst_req) begin
                    state_d     = ST_SWRST;
                    sys_rst_n_d = 1'b0;
                    ack_d       = 1'b1;
                    cause_d     = 2'b10;
                    if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_SYNC;
                sys_rst_n_d = 1'b0;
                ctr_d       = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SYNC;
            sync_q      <= 2'b00;
            ctr_q       <= 8'd0;
            sys_rst_n_q <= 1'b0;
            ack_q       <= 1'b0;
            cause_q     <= 2'b01;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            ctr_q       <= ctr_d;
            sys_rst_n_q <= sys_rst_n_d;
            ack_q       <= ack_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rs.sys_rst_n   = sys_rst_n_q;
    assign rs.sys_rst_ack = ack_q;
    assign rs.rst_cause   = cause_q;
    assign rs.sw_rst_cnt  = cnt_q;

endmodule
